// File: rtl/bram_sweep_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bram_ctrl_pkg : shared types for the sweeping block-RAM controller. Rev 1.0
// ----------------------------------------------------------------------------
package bram_ctrl_pkg;

  typedef enum logic [0:0] {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Index of a granted write requester (0 or 1).
  typedef logic gnt_idx_t;

endpackage : bram_ctrl_pkg
`default_nettype wire

// File: rtl/bram_sweep_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bram_sweep_arbiter_if : requester, read and RAM-side signals. Rev 1.0
// ----------------------------------------------------------------------------
interface bram_sweep_arbiter_if #(
  parameter int LEN_DATA = 20,
  parameter int LEN_ADDR = 8
);
  logic                flush_req;
  logic                busy;
  logic                w0_valid;
  logic                w0_ready;
  logic [LEN_ADDR-1:0] w0_addr;
  logic [LEN_DATA-1:0] w0_data;
  logic                w1_valid;
  logic                w1_ready;
  logic [LEN_ADDR-1:0] w1_addr;
  logic [LEN_DATA-1:0] w1_data;
  logic                rd_en;
  logic [LEN_ADDR-1:0] rd_addr;
  logic                rd_ready;
  logic                rd_valid;
  logic [LEN_DATA-1:0] rd_data;
  logic                ram_ena;
  logic                ram_wea;
  logic [LEN_ADDR-1:0] ram_addra;
  logic [LEN_DATA-1:0] ram_dina;
  logic                ram_enb;
  logic [LEN_ADDR-1:0] ram_addrb;
  logic [LEN_DATA-1:0] ram_doutb;

  modport master (
    output flush_req, w0_valid, w0_addr, w0_data, w1_valid, w1_addr, w1_data,
           rd_en, rd_addr, ram_doutb,
    input  busy, w0_ready, w1_ready, rd_ready, rd_valid, rd_data,
           ram_ena, ram_wea, ram_addra, ram_dina, ram_enb, ram_addrb
  );

  modport slave (
    input  flush_req, w0_valid, w0_addr, w0_data, w1_valid, w1_addr, w1_data,
           rd_en, rd_addr, ram_doutb,
    output busy, w0_ready, w1_ready, rd_ready, rd_valid, rd_data,
           ram_ena, ram_wea, ram_addra, ram_dina, ram_enb, ram_addrb
  );

endinterface : bram_sweep_arbiter_if
`default_nettype wire

// File: rtl/bram_sweep_arbiter_rr_arb2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arb2 : two-way round-robin arbiter, combinational grant. Rev 1.0
// ----------------------------------------------------------------------------
module rr_arb2
  import bram_ctrl_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       en_i,
  input  wire logic [1:0] req_i,
  output logic      [1:0] gnt_o,
  output gnt_idx_t        idx_o
);

  gnt_idx_t ptr_q;
  gnt_idx_t ptr_d;
  logic     any_w;

  always_comb begin
    any_w = en_i && (req_i != 2'b00);
    case (req_i)
      2'b01:   idx_o = 1'b0;
      2'b10:   idx_o = 1'b1;
      default: idx_o = ptr_q;
    endcase
    gnt_o = any_w ? (idx_o ? 2'b10 : 2'b01) : 2'b00;
    // Whoever wins, the other requester gets priority next time.
    ptr_d = any_w ? ~idx_o : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/bram_sweep_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bram_sweep_arbiter : clears a dual-port BRAM, arbitrates port A, bypasses
// same-cycle writes to port B reads. Rev 1.0
// ----------------------------------------------------------------------------
module bram_sweep_arbiter
  import bram_ctrl_pkg::*;
#(
  parameter int                  LEN_DATA  = 20,
  parameter int                  LEN_ADDR  = 8,
  parameter logic [LEN_DATA-1:0] CLEAR_VAL = '0
) (
  input wire logic            clk,
  input wire logic            rst,
  bram_sweep_arbiter_if.slave bus
);

  state_e              state_q;
  logic [LEN_ADDR-1:0] cnt_q;
  logic                rd_valid_q;
  logic                byp_hit_q;
  logic [LEN_DATA-1:0] byp_data_q;
  logic [LEN_DATA-1:0] rd_hold_q;

  logic                in_sweep_w;
  logic                run_ok_w;
  logic [1:0]          gnt_w;
  gnt_idx_t            gnt_idx_w;
  logic                wr_gnt_w;
  logic [LEN_ADDR-1:0] wr_addr_w;
  logic [LEN_DATA-1:0] wr_data_w;
  logic                rd_acc_w;
  logic [LEN_DATA-1:0] rd_data_d;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en_i  (run_ok_w),
    .req_i ({bus.w1_valid, bus.w0_valid}),
    .gnt_o (gnt_w),
    .idx_o (gnt_idx_w)
  );

  always_comb begin
    in_sweep_w = !rst && (state_q == SWEEP);
    run_ok_w   = !rst && (state_q == RUN) && !bus.flush_req;
    wr_gnt_w   = gnt_w != 2'b00;
    wr_addr_w  = gnt_idx_w ? bus.w1_addr : bus.w0_addr;
    wr_data_w  = gnt_idx_w ? bus.w1_data : bus.w0_data;
    rd_acc_w   = bus.rd_en && run_ok_w;
    rd_data_d  = rd_valid_q ? (byp_hit_q ? byp_data_q : bus.ram_doutb) : rd_hold_q;
  end

  assign bus.busy      = rst || (state_q == SWEEP);
  assign bus.w0_ready  = gnt_w[0];
  assign bus.w1_ready  = gnt_w[1];
  assign bus.rd_ready  = run_ok_w;
  assign bus.ram_ena   = in_sweep_w || wr_gnt_w;
  assign bus.ram_wea   = in_sweep_w || wr_gnt_w;
  assign bus.ram_addra = in_sweep_w ? cnt_q : wr_addr_w;
  assign bus.ram_dina  = in_sweep_w ? CLEAR_VAL : wr_data_w;
  assign bus.ram_enb   = rd_acc_w;
  assign bus.ram_addrb = bus.rd_addr;
  assign bus.rd_valid  = !rst && rd_valid_q;
  assign bus.rd_data   = rst ? '0 : rd_data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        SWEEP: begin
          cnt_q <= cnt_q + 1'b1;
          if (&cnt_q) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (bus.flush_req) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
          end
        end
        default: state_q <= SWEEP;
      endcase
    end
  end

  // The RAM output is only trustworthy in the completion cycle, so the
  // delivered word is captured then and replayed until the next read lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      byp_hit_q  <= 1'b0;
      byp_data_q <= '0;
      rd_hold_q  <= '0;
    end else begin
      rd_valid_q <= rd_acc_w;
      if (rd_valid_q) begin
        rd_hold_q <= rd_data_d;
      end
      if (rd_acc_w) begin
        byp_hit_q  <= wr_gnt_w && (wr_addr_w == bus.rd_addr);
        byp_data_q <= wr_data_w;
      end
    end
  end

endmodule : bram_sweep_arbiter
`default_nettype wire

// File: tb/tb_bram_sweep_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bram_sweep_arbiter : directed + random stimulus against a behavioural
// model of the controller and a simple RAM. Rev 1.0
// ----------------------------------------------------------------------------
module tb_bram_sweep_arbiter;

  localparam int        LA    = 4;
  localparam int        LD    = 8;
  localparam int        DEPTH = 16;
  localparam logic [7:0] CV   = 8'hA5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bram_sweep_arbiter_if #(.LEN_DATA(LD), .LEN_ADDR(LA)) bus ();

  bram_sweep_arbiter #(
    .LEN_DATA (LD),
    .LEN_ADDR (LA),
    .CLEAR_VAL(CV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Simple dual-port RAM with registered port B.
  logic [7:0] ram [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_ena && bus.ram_wea) ram[bus.ram_addra] <= bus.ram_dina;
    if (bus.ram_enb) bus.ram_doutb <= ram[bus.ram_addrb];
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] m_mem [DEPTH];
  int         m_sweep;   // sweep writes still to come
  int         m_pref;    // requester favoured on a tie
  bit         m_rdv;
  logic [7:0] m_rdata;
  int         last_g;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    bus.flush_req = 0; bus.rd_en = 0; bus.rd_addr = '0;
    bus.w0_valid = 0; bus.w0_addr = '0; bus.w0_data = '0;
    bus.w1_valid = 0; bus.w1_addr = '0; bus.w1_data = '0;
  endtask

  task automatic step();
    int g; bit acc; bit r; bit fl; logic [3:0] wa; logic [7:0] wd; logic [3:0] ra;
    g = -1; acc = 0; wa = '0; wd = '0;
    #4;
    r = rst; fl = bus.flush_req; ra = bus.rd_addr;
    if (r) begin
      chk("rst_busy", bus.busy, 1);
      chk("rst_en", {bus.ram_ena, bus.ram_wea, bus.ram_enb}, 0);
      chk("rst_rdy", {bus.w0_ready, bus.w1_ready, bus.rd_ready}, 0);
      chk("rst_rdv", bus.rd_valid, 0);
      chk("rst_rdd", bus.rd_data, 0);
    end else begin
      chk("rd_valid", bus.rd_valid, m_rdv);
      chk("rd_data", bus.rd_data, m_rdata);
      if (m_sweep > 0) begin
        chk("sw_busy", bus.busy, 1);
        chk("sw_en", {bus.ram_ena, bus.ram_wea, bus.ram_enb}, 3'b110);
        chk("sw_addr", bus.ram_addra, DEPTH - m_sweep);
        chk("sw_din", bus.ram_dina, CV);
        chk("sw_rdy", {bus.w0_ready, bus.w1_ready, bus.rd_ready}, 0);
      end else if (fl) begin
        chk("fl_busy", bus.busy, 0);
        chk("fl_en", {bus.ram_ena, bus.ram_enb}, 0);
        chk("fl_rdy", {bus.w0_ready, bus.w1_ready, bus.rd_ready}, 0);
      end else begin
        if (bus.w0_valid && bus.w1_valid) g = m_pref;
        else if (bus.w0_valid) g = 0;
        else if (bus.w1_valid) g = 1;
        acc = bus.rd_en;
        chk("busy", bus.busy, 0);
        chk("grant", {bus.w1_ready, bus.w0_ready}, (g < 0) ? 0 : ((g == 1) ? 2 : 1));
        chk("rd_ready", bus.rd_ready, 1);
        chk("wr_en", {bus.ram_ena, bus.ram_wea}, (g < 0) ? 0 : 3);
        if (g >= 0) begin
          wa = (g == 1) ? bus.w1_addr : bus.w0_addr;
          wd = (g == 1) ? bus.w1_data : bus.w0_data;
          chk("addra", bus.ram_addra, wa);
          chk("dina", bus.ram_dina, wd);
        end
        chk("enb", bus.ram_enb, acc);
        if (acc) chk("addrb", bus.ram_addrb, ra);
      end
    end
    @(posedge clk);
    last_g = -1;
    if (r) begin
      m_sweep = DEPTH; m_pref = 0; m_rdv = 0; m_rdata = '0;
    end else if (m_sweep > 0) begin
      m_mem[DEPTH - m_sweep] = CV;
      m_sweep--;
      m_rdv = 0;
    end else if (fl) begin
      m_sweep = DEPTH;
      m_rdv = 0;
    end else begin
      m_rdv = acc;
      if (acc) m_rdata = (g >= 0 && wa == ra) ? wd : m_mem[ra];
      if (g >= 0) begin
        m_mem[wa] = wd;
        m_pref = 1 - g;
        last_g = g;
      end
    end
    #1;
  endtask

  task automatic check_mem();
    for (int i = 0; i < DEPTH; i++) chk($sformatf("mem[%0d]", i), ram[i], m_mem[i]);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_sweep = 0; m_pref = 0; m_rdv = 0; m_rdata = '0; last_g = -1;
    idle();
    rst = 1;
    step(); step();
    rst = 0;

    // Initial sweep, then read address 7
    for (int i = 0; i < DEPTH; i++) step();
    chk("post_sweep_busy", bus.busy, 0);
    check_mem();
    bus.rd_en = 1; bus.rd_addr = 4'd7; step();
    bus.rd_en = 0; step();
    chk("rd7_clear", bus.rd_data, 8'hA5);

    // Both requesters held valid: grants alternate
    bus.w0_valid = 1; bus.w0_addr = 4'd3; bus.w0_data = 8'h11;
    bus.w1_valid = 1; bus.w1_addr = 4'd4; bus.w1_data = 8'h22;
    for (int i = 0; i < 6; i++) step();
    idle(); step();
    chk("mem3", ram[3], 8'h11);
    chk("mem4", ram[4], 8'h22);

    // Same-cycle write/read bypass, then read back from RAM
    bus.w0_valid = 1; bus.w0_addr = 4'd9; bus.w0_data = 8'h5A;
    bus.rd_en = 1; bus.rd_addr = 4'd9; step();
    idle(); step();
    chk("bypass", bus.rd_data, 8'h5A);
    bus.rd_en = 1; bus.rd_addr = 4'd9; step();
    idle(); step();
    chk("ram_5A", bus.rd_data, 8'h5A);

    // Flush with pending write and read
    bus.w0_valid = 1; bus.w0_addr = 4'd2; bus.w0_data = 8'h33;
    bus.rd_en = 1; bus.rd_addr = 4'd0; bus.flush_req = 1; step();
    bus.flush_req = 0; bus.rd_en = 0;
    for (int i = 0; i < DEPTH; i++) step();
    step();
    bus.w0_valid = 0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.rd_en = 1; bus.rd_addr = 4'(i); step();
    end
    idle(); step();

    // Reset in the middle of a sweep
    bus.flush_req = 1; step();
    bus.flush_req = 0;
    for (int i = 0; i < 6; i++) step();
    rst = 1; step();
    rst = 0;
    for (int i = 0; i < DEPTH + 2; i++) step();

    // Write to the read address in the cycle after the read
    bus.rd_en = 1; bus.rd_addr = 4'd5; step();
    bus.rd_en = 0; bus.w0_valid = 1; bus.w0_addr = 4'd5; bus.w0_data = 8'h77; step();
    idle();
    for (int i = 0; i < 3; i++) step();
    chk("hold_prewrite", bus.rd_data, 8'hA5);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      if (!bus.w0_valid || last_g == 0) begin
        bus.w0_valid = 1'($urandom_range(0, 1));
        bus.w0_addr = 4'($urandom); bus.w0_data = 8'($urandom);
      end
      if (!bus.w1_valid || last_g == 1) begin
        bus.w1_valid = 1'($urandom_range(0, 1));
        bus.w1_addr = 4'($urandom); bus.w1_data = 8'($urandom);
      end
      bus.rd_en = 1'($urandom_range(0, 1));
      bus.rd_addr = ($urandom_range(0, 1) == 1) ? bus.w0_addr : 4'($urandom);
      bus.flush_req = ($urandom_range(0, 59) == 0);
      rst = ($urandom_range(0, 249) == 0);
      step();
    end
    rst = 0; idle();
    for (int i = 0; i < DEPTH + 2; i++) step();
    check_mem();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_bram_sweep_arbiter
`default_nettype wire
